rns2bin_crt_ctrl: RTL and testbench
===================================

Name: rns2bin_crt_ctrl

Overview:
Sequential CRT-based RNS-to-binary converter with its own configuration sequencer. After a configuration request it computes the dynamic range M, every Q_i = M/m_i and every modular inverse A_i, using an iterative search. It then accepts residue vectors through a valid/ready handshake. Each vector is reconstructed by accumulating one modulus term per cycle, and the binary result is presented on a held output handshake. It sits between the RNS arithmetic units and the binary-domain back end.

Parameters:
MOD_NUM, 4, number of moduli (structure fixed at 4 ports; parameter sizes loops)
MOD_SIZE, 3, residue width in bits; moduli are MOD_SIZE+1 bits wide
RANGE, MOD_NUM*MOD_SIZE, width of M, Q_i, A_i and the output n

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  configuration request; sampled together with mod_1..mod_4
cfg_ready  out  1  high only in IDLE and READY
mod_1, mod_2, mod_3, mod_4  in  MOD_SIZE+1  moduli, which must be pairwise coprime
cfg_done  out  1  level; high while a valid configuration is held
cfg_err  out  1  sticky error flag; cleared by the next accepted cfg_valid
in_valid  in  1  residue vector valid
in_ready  out  1  high only in READY
c0, c1, c2, c3  in  MOD_SIZE  residues for mod_1..mod_4
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  result consumed
n  out  RANGE  reconstructed value

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - cfg_done=0, cfg_err=0, out_valid=0, n=0, in_ready=0, cfg_ready=1.
  - All stored moduli, Q_i and A_i are invalidated.
- States: IDLE, CFG_Q, CFG_INV, READY, ACC, DONE.
- IDLE:
  - cfg_valid=1 latches the moduli, clears cfg_err and goes to CFG_Q.
  - in_valid is ignored.
- CFG_Q (1 cycle):
  - M is the product of the moduli, computed at 4*(MOD_SIZE+1) bits.
  - Q_i is the product of all moduli except m_i.
  - Error if any m_i<2 or if M>=2^RANGE: set cfg_err=1, cfg_done=0, go to IDLE.
  - Otherwise go to CFG_INV with i=0, k=1.
- CFG_INV (one candidate per cycle):
  - r_i = Q_i mod m_i.
  - If (r_i*k) mod m_i == 1: A_i=k, advance i, reset k=1.
  - Otherwise increment k.
  - If k reaches m_i with no match: set cfg_err=1 and go to IDLE (moduli not coprime).
  - After i=MOD_NUM-1 succeeds: cfg_done=1, go to READY.
- READY:
  - in_ready=1 and cfg_ready=1.
  - in_valid wins over a simultaneous cfg_valid; the cfg request must be re-presented later.
  - Accept latches c0..c3, clears acc=0 and idx=0, and goes to ACC.
  - cfg_valid alone starts reconfiguration; cfg_done drops on the same edge.
- ACC, one edge per idx:
  - t = ((C[idx]*A[idx]) mod m[idx]) * Q[idx]; t < M.
  - s = acc + t; acc = (s >= M) ? s-M : s, so acc stays in [0, M).
  - Residues >= m_i are legal; they are reduced implicitly.
  - On idx=MOD_NUM-1: load n from the final acc, set out_valid=1, go to DONE.
  - out_valid rises on the MOD_NUM-th edge after the accepting edge.
- DONE:
  - n and out_valid are held stable.
  - When out_valid&out_ready: out_valid=0, go to READY. in_ready returns one cycle later (no bypass).
- cfg_valid in CFG_Q, CFG_INV, ACC or DONE is ignored (cfg_ready=0).
- Reset mid-operation discards the vector and the configuration.

Optional Feature:
Macro RNS_SIGNED_OUT_EN.
- Defined: n is loaded as (acc >= (M>>1)) ? acc-M : acc, as RANGE-bit two's complement, giving range [-(M>>1), M-(M>>1)-1]. Latency is unchanged.
- Undefined: n = acc, unsigned in [0, M).

Test Plan:
- Config 3,5,7,8 -> cfg_done=1, cfg_err=0; A = {1,2,1,1}; M=840.
- After that config, residues (1,0,2,4) -> out_valid 4 edges after accept, n=100 in both builds.
- Residues (2,0,3,4) -> unsigned build n=500; signed build n=12'hEAC (-340).
- Config 4,6,5,7 -> cfg_err=1, cfg_done=0, state IDLE; in_valid is ignored afterwards.
- out_ready held low for 3 cycles in DONE -> n stable, in_ready=0, a cfg_valid pulse is ignored; after the handshake, in_ready=1 one cycle later.
- reset pulsed low during ACC -> out_valid=0 and cfg_done=0 immediately; a new config is required before in_ready=1.

Source files
------------

// File: rtl/rns2bin_crt_ctrl.sv
// CRT-based RNS-to-binary converter with on-chip Q_i / A_i configuration.
// Define RNS_SIGNED_OUT_EN for a two's complement result centred on zero.
module rns2bin_crt_ctrl #(
   parameter int MOD_NUM  = 4,
   parameter int MOD_SIZE = 3,
   parameter int RANGE    = MOD_NUM*MOD_SIZE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [MOD_SIZE:0]   mod_1,
   input  logic [MOD_SIZE:0]   mod_2,
   input  logic [MOD_SIZE:0]   mod_3,
   input  logic [MOD_SIZE:0]   mod_4,
   output logic                cfg_done,
   output logic                cfg_err,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MOD_SIZE-1:0] c0,
   input  logic [MOD_SIZE-1:0] c1,
   input  logic [MOD_SIZE-1:0] c2,
   input  logic [MOD_SIZE-1:0] c3,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [RANGE-1:0]    n
);

   localparam int MW = MOD_SIZE+1;
   localparam int PW = MOD_NUM*MW;
   localparam int IW = (MOD_NUM > 1) ? $clog2(MOD_NUM) : 1;

   typedef enum logic [2:0] {
      IDLE, CFG_Q, CFG_INV, READY, ACC, DONE
   } state_t;

   state_t               state;
   logic [MW-1:0]        m [MOD_NUM];
   logic [MOD_SIZE-1:0]  c [MOD_NUM];
   logic [RANGE-1:0]     q [MOD_NUM];
   logic [MW-1:0]        a [MOD_NUM];
   logic [RANGE-1:0]     m_tot;
   logic [RANGE-1:0]     acc;
   logic [IW-1:0]        idx;
   logic [MW-1:0]        k;

   logic [PW-1:0]        p_all;
   logic [PW-1:0]        p_q [MOD_NUM];
   logic                 bad;

   // products are formed at full width so an oversized M is detectable
   always_comb begin
      p_all = PW'(1);
      bad   = 1'b0;
      for (int i = 0; i < MOD_NUM; i++) begin
         p_all  = p_all * PW'(m[i]);
         bad    = bad | (m[i] < MW'(2));
         p_q[i] = PW'(1);
         for (int j = 0; j < MOD_NUM; j++)
            if (j != i)
               p_q[i] = p_q[i] * PW'(m[j]);
      end
      bad = bad | (p_all > PW'({RANGE{1'b1}}));
   end

   logic [MW-1:0]   r;
   logic [2*MW-1:0] rk;
   logic            hit;

   always_comb begin
      r   = MW'(q[idx] % RANGE'(m[idx]));
      rk  = (2*MW)'(r) * (2*MW)'(k);
      hit = (rk % (2*MW)'(m[idx])) == (2*MW)'(1);
   end

   logic [MW-1:0]    cm;
   logic [RANGE-1:0] t;
   logic [RANGE:0]   s;
   logic [RANGE-1:0] acc_nx;
   logic [RANGE-1:0] n_nx;

   always_comb begin
      cm = MW'((PW'(c[idx]) * PW'(a[idx])) % PW'(m[idx]));
      t  = RANGE'(PW'(cm) * PW'(q[idx]));
      s  = {1'b0, acc} + {1'b0, t};
      acc_nx = (s >= {1'b0, m_tot}) ? RANGE'(s - {1'b0, m_tot})
                                    : RANGE'(s);
`ifdef RNS_SIGNED_OUT_EN
      n_nx = (acc_nx >= (m_tot >> 1)) ? acc_nx - m_tot : acc_nx;
`else
      n_nx = acc_nx;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cfg_ready <= 1'b1;
         in_ready  <= 1'b0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         out_valid <= 1'b0;
         n         <= '0;
         acc       <= '0;
         m_tot     <= '0;
         idx       <= '0;
         k         <= MW'(1);
         for (int i = 0; i < MOD_NUM; i++) begin
            m[i] <= '0;
            c[i] <= '0;
            q[i] <= '0;
            a[i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (cfg_valid) begin
                  m[0]      <= mod_1;
                  m[1]      <= mod_2;
                  m[2]      <= mod_3;
                  m[3]      <= mod_4;
                  cfg_err   <= 1'b0;
                  cfg_ready <= 1'b0;
                  state     <= CFG_Q;
               end
            end
            CFG_Q: begin
               if (bad) begin
                  cfg_err   <= 1'b1;
                  cfg_done  <= 1'b0;
                  cfg_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  m_tot <= RANGE'(p_all);
                  for (int i = 0; i < MOD_NUM; i++)
                     q[i] <= RANGE'(p_q[i]);
                  idx   <= '0;
                  k     <= MW'(1);
                  state <= CFG_INV;
               end
            end
            CFG_INV: begin
               // one inverse candidate k per cycle for modulus idx
               if (hit) begin
                  a[idx] <= k;
                  k      <= MW'(1);
                  if (idx == IW'(MOD_NUM-1)) begin
                     cfg_done  <= 1'b1;
                     in_ready  <= 1'b1;
                     cfg_ready <= 1'b1;
                     state     <= READY;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end else if (k + MW'(1) == m[idx]) begin
                  cfg_err   <= 1'b1;
                  cfg_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  k <= k + MW'(1);
               end
            end
            READY: begin
               if (in_valid) begin
                  c[0]      <= c0;
                  c[1]      <= c1;
                  c[2]      <= c2;
                  c[3]      <= c3;
                  acc       <= '0;
                  idx       <= '0;
                  in_ready  <= 1'b0;
                  cfg_ready <= 1'b0;
                  state     <= ACC;
               end else if (cfg_valid) begin
                  m[0]      <= mod_1;
                  m[1]      <= mod_2;
                  m[2]      <= mod_3;
                  m[3]      <= mod_4;
                  cfg_err   <= 1'b0;
                  cfg_done  <= 1'b0;
                  in_ready  <= 1'b0;
                  cfg_ready <= 1'b0;
                  state     <= CFG_Q;
               end
            end
            ACC: begin
               acc <= acc_nx;
               if (idx == IW'(MOD_NUM-1)) begin
                  n         <= n_nx;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  cfg_ready <= 1'b1;
                  state     <= READY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rns2bin_crt_ctrl.sv
// Directed bench for rns2bin_crt_ctrl; expectations follow the
// RNS_SIGNED_OUT_EN setting of the build.
module tb_rns2bin_crt_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [3:0]  mod_1 = '0, mod_2 = '0, mod_3 = '0, mod_4 = '0;
   logic        cfg_done, cfg_err;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  c0 = '0, c1 = '0, c2 = '0, c3 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] n;

   int vectors = 0;
   int errs = 0;

`ifdef RNS_SIGNED_OUT_EN
   localparam logic [11:0] EXP2 = 12'hEAC;
`else
   localparam logic [11:0] EXP2 = 12'd500;
`endif

   rns2bin_crt_ctrl dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .mod_1(mod_1), .mod_2(mod_2), .mod_3(mod_3), .mod_4(mod_4),
      .cfg_done(cfg_done), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready),
      .c0(c0), .c1(c1), .c2(c2), .c3(c3),
      .out_valid(out_valid), .out_ready(out_ready), .n(n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mods(input logic [3:0] a, b, c, d);
      mod_1 = a; mod_2 = b; mod_3 = c; mod_4 = d;
   endtask

   task automatic wait_cfg();
      int cnt = 0;
      while (!(cfg_done || cfg_err) && cnt < 50) begin
         tick();
         cnt++;
      end
      check("cfg_timeout", 32'(cnt < 50), 1);
   endtask

   task automatic do_cfg(input logic [3:0] a, b, c, d);
      set_mods(a, b, c, d);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      check("cfg_err_clr", cfg_err, 0);
      wait_cfg();
   endtask

   task automatic send(input logic [2:0] a, b, c, d);
      c0 = a; c1 = b; c2 = c; c3 = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int cnt = 0;
      while (!out_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      check("out_timeout", 32'(cnt < 20), 1);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b0;
      #2;
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_cfg_done", cfg_done, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_n", n, 0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      set_mods(4'd3, 4'd5, 4'd7, 4'd8);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      check("cfg_ready_busy", cfg_ready, 0);
      wait_cfg();
      check("cfg1_done", cfg_done, 1);
      check("cfg1_err", cfg_err, 0);
      check("cfg1_in_ready", in_ready, 1);
      check("cfg1_cfg_ready", cfg_ready, 1);

      send(3'd1, 3'd0, 3'd2, 3'd4);
      check("acc_in_ready", in_ready, 0);
      tick();
      tick();
      tick();
      check("lat_edge3", out_valid, 0);
      tick();
      check("lat_edge4", out_valid, 1);
      check("vec1_n", n, 100);
      handshake();
      check("hs1_out_valid", out_valid, 0);
      check("hs1_in_ready", in_ready, 1);

      send(3'd2, 3'd0, 3'd3, 3'd4);
      wait_out();
      check("vec2_n", n, EXP2);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            set_mods(4'd4, 4'd6, 4'd5, 4'd7);
            cfg_valid = 1'b1;
         end
         tick();
         cfg_valid = 1'b0;
         check("hold_n", n, EXP2);
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_cfg_ready", cfg_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check("hs2_in_ready_lo", in_ready, 0);
      tick();
      out_ready = 1'b0;
      check("hs2_in_ready", in_ready, 1);
      check("hs2_cfg_done", cfg_done, 1);

      c0 = 3'd7; c1 = 3'd7; c2 = 3'd7; c3 = 3'd7;
      set_mods(4'd4, 4'd6, 4'd5, 4'd7);
      in_valid = 1'b1;
      cfg_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cfg_valid = 1'b0;
      check("prio_in_ready", in_ready, 0);
      check("prio_cfg_done", cfg_done, 1);
      wait_out();
      check("big_res_n", n, 7);
      handshake();

      set_mods(4'd4, 4'd6, 4'd5, 4'd7);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      check("recfg_done_drop", cfg_done, 0);
      wait_cfg();
      check("copr_err", cfg_err, 1);
      check("copr_done", cfg_done, 0);
      check("copr_cfg_ready", cfg_ready, 1);
      check("copr_in_ready", in_ready, 0);
      in_valid = 1'b1;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      check("idle_in_ready", in_ready, 0);
      check("idle_out_valid", out_valid, 0);

      do_cfg(4'd1, 4'd5, 4'd7, 4'd8);
      check("small_mod_err", cfg_err, 1);
      check("small_mod_done", cfg_done, 0);
      do_cfg(4'd7, 4'd9, 4'd11, 4'd13);
      check("ovf_err", cfg_err, 1);
      check("ovf_done", cfg_done, 0);

      do_cfg(4'd3, 4'd5, 4'd7, 4'd8);
      check("cfg2_done", cfg_done, 1);
      check("cfg2_err", cfg_err, 0);
      send(3'd2, 3'd0, 3'd3, 3'd4);
      wait_out();
      check("vec3_n", n, EXP2);
      handshake();

      send(3'd1, 3'd0, 3'd2, 3'd4);
      tick();
      tick();
      #1 reset = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_cfg_done", cfg_done, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_cfg_ready", cfg_ready, 1);
      reset = 1'b1;
      in_valid = 1'b1;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_out_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
